// File: rtl/bomb_pkg.sv
// Shared constants, FSM state type and a span-test helper for the bomb controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bomb_pkg;

  localparam logic [9:0] TILE        = 10'd32;
  localparam logic [9:0] TILE_MASK   = ~(TILE - 10'd1);
  localparam logic [9:0] ARENA_X_MIN = 10'd32;
  localparam logic [9:0] ARENA_X_END = 10'd576;
  localparam logic [9:0] ARENA_Y_MIN = 10'd32;
  localparam logic [9:0] ARENA_Y_END = 10'd448;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BLAST = 2'd2
  } state_t;

  // Half-open span test [org, org+len); evaluated in 11 bits so the end of a
  // span near the top of the 10-bit range cannot wrap. A zero len never hits.
  function automatic logic in_span(input logic [9:0] p,
                                   input logic [9:0] org,
                                   input logic [9:0] len);
    return (p >= org) && ({1'b0, p} < ({1'b0, org} + {1'b0, len}));
  endfunction

endpackage

// File: rtl/blast_clip.sv
// Clips one blast arm (tile before .. tile after the bomb) to the arena bounds.
// Latency: combinational.
// Backpressure: none.
// Ports: origin = bomb tile origin on this axis; lo/hi = arena start/end;
//        start/size = clipped arm origin and length (size 0 if fully clipped).
module blast_clip
  import bomb_pkg::*;
(
  input  logic [9:0] origin,
  input  logic [9:0] lo,
  input  logic [9:0] hi,
  output logic [9:0] start,
  output logic [9:0] size
);

  localparam logic [10:0] TILE_W = {1'b0, TILE};

  logic [10:0] far_edge;
  logic [10:0] end_pos;

  always_comb begin
    // Compare before subtracting so a bomb at the arena edge never underflows.
    if ({1'b0, origin} < ({1'b0, lo} + TILE_W)) begin
      start = lo;
    end else begin
      start = origin - TILE;
    end

    far_edge = {1'b0, origin} + TILE_W + TILE_W;
    end_pos  = (far_edge > {1'b0, hi}) ? {1'b0, hi} : far_edge;

    // A bomb latched beyond the arena can leave end below start; report an
    // empty arm instead of a wrapped size.
    if (end_pos > {1'b0, start}) begin
      size = 10'(end_pos - {1'b0, start});
    end else begin
      size = '0;
    end
  end

endmodule

// File: rtl/bomb_ctrl.sv
// Single-bomb controller: arm on drop edge, run fuse, hold blast, back to idle.
// Latency: bomb_active one frame after the drop edge; blast FUSE_FRAMES later.
// Backpressure: none; drop edges while a bomb exists are discarded.
// Ports: frame_clk/Reset; bomb_drop, userX/userY (player); DrawX/DrawY (pixel);
//        bomb_active, bombX/bombY, blast, blastH*/blastV* rectangles, and the
//        combinational bomb_on/blast_on pixel hit flags.
module bomb_ctrl
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       bomb_drop,
  input  logic [9:0] userX,
  input  logic [9:0] userY,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       bomb_active,
  output logic [9:0] bombX,
  output logic [9:0] bombY,
  output logic       blast,
  output logic [9:0] blastHX,
  output logic [9:0] blastHY,
  output logic [9:0] blastHXS,
  output logic [9:0] blastHYS,
  output logic [9:0] blastVX,
  output logic [9:0] blastVY,
  output logic [9:0] blastVXS,
  output logic [9:0] blastVYS,
  output logic       bomb_on,
  output logic       blast_on
);

  localparam int MAX_FRAMES = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
  localparam int CW         = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [CW-1:0] FUSE_LOAD  = CW'(FUSE_FRAMES - 1);
  localparam logic [CW-1:0] BLAST_LOAD = CW'(BLAST_FRAMES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    bomb_x_q, bomb_x_d;
  logic [9:0]    bomb_y_q, bomb_y_d;
  logic          drop_q;
  logic          primed_q;
  logic          drop_rise;

  logic [9:0]    h_start, h_size, v_start, v_size;

  // primed_q stays low after reset until bomb_drop has been seen low once, so
  // a button held through reset cannot look like a fresh edge.
  assign drop_rise = bomb_drop & ~drop_q & primed_q;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bomb_x_q <= '0;
      bomb_y_q <= '0;
      drop_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bomb_x_q <= bomb_x_d;
      bomb_y_q <= bomb_y_d;
      drop_q   <= bomb_drop;
      primed_q <= primed_q | ~bomb_drop;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bomb_x_d = bomb_x_q;
    bomb_y_d = bomb_y_q;
    case (state_q)
      IDLE: begin
        if (drop_rise) begin
          state_d  = ARMED;
          cnt_d    = FUSE_LOAD;
          // Snap the player's centre to the tile grid.
          bomb_x_d = (userX + 10'd9)  & TILE_MASK;
          bomb_y_d = (userY + 10'd13) & TILE_MASK;
        end
      end
      ARMED: begin
        if (cnt_q == '0) begin
          state_d = BLAST;
          cnt_d   = BLAST_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BLAST: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          cnt_d    = '0;
          bomb_x_d = '0;
          bomb_y_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        bomb_x_d = '0;
        bomb_y_d = '0;
      end
    endcase
  end

  blast_clip u_clip_h (
    .origin (bomb_x_q),
    .lo     (ARENA_X_MIN),
    .hi     (ARENA_X_END),
    .start  (h_start),
    .size   (h_size)
  );

  blast_clip u_clip_v (
    .origin (bomb_y_q),
    .lo     (ARENA_Y_MIN),
    .hi     (ARENA_Y_END),
    .start  (v_start),
    .size   (v_size)
  );

  assign bomb_active = (state_q == ARMED);
  assign blast       = (state_q == BLAST);
  assign bombX       = bomb_x_q;
  assign bombY       = bomb_y_q;

  assign blastHX  = blast ? h_start  : '0;
  assign blastHXS = blast ? h_size   : '0;
  assign blastHY  = blast ? bomb_y_q : '0;
  assign blastHYS = blast ? TILE     : '0;
  assign blastVX  = blast ? bomb_x_q : '0;
  assign blastVXS = blast ? TILE     : '0;
  assign blastVY  = blast ? v_start  : '0;
  assign blastVYS = blast ? v_size   : '0;

  assign bomb_on = bomb_active
                 & in_span(DrawX, bomb_x_q, TILE)
                 & in_span(DrawY, bomb_y_q, TILE);

  assign blast_on = blast
                  & ((in_span(DrawX, blastHX, blastHXS) & in_span(DrawY, blastHY, blastHYS))
                   | (in_span(DrawX, blastVX, blastVXS) & in_span(DrawY, blastVY, blastVYS)));

endmodule

// File: tb/tb_bomb_ctrl.sv
module tb_bomb_ctrl;

  localparam int F = 120;
  localparam int B = 30;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b0;
  logic       bomb_drop = 1'b0;
  logic [9:0] userX = '0, userY = '0, DrawX = '0, DrawY = '0;
  logic       bomb_active, blast, bomb_on, blast_on;
  logic [9:0] bombX, bombY;
  logic [9:0] blastHX, blastHY, blastHXS, blastHYS;
  logic [9:0] blastVX, blastVY, blastVXS, blastVYS;

  always #5 frame_clk = ~frame_clk;

  bomb_ctrl #(.FUSE_FRAMES(F), .BLAST_FRAMES(B)) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .bomb_drop   (bomb_drop),
    .userX       (userX),
    .userY       (userY),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .bomb_active (bomb_active),
    .bombX       (bombX),
    .bombY       (bombY),
    .blast       (blast),
    .blastHX     (blastHX),
    .blastHY     (blastHY),
    .blastHXS    (blastHXS),
    .blastHYS    (blastHYS),
    .blastVX     (blastVX),
    .blastVY     (blastVY),
    .blastVXS    (blastVXS),
    .blastVYS    (blastVYS),
    .bomb_on     (bomb_on),
    .blast_on    (blast_on)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model: elapsed frames since arming ----------
  int m_n, m_a, m_bx, m_by;
  bit m_armed, m_prev, m_primed, m_idle_before, m_rise;

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_n = 0; m_a = 0; m_bx = 0; m_by = 0;
      m_armed = 0; m_prev = 0; m_primed = 0;
    end else begin
      m_idle_before = !m_armed || ((m_n - m_a) >= F + B);
      m_rise        = bomb_drop && !m_prev && m_primed;
      m_n++;
      if (m_idle_before && m_rise) begin
        m_armed = 1;
        m_a     = m_n;
        m_bx    = ((int'(userX) + 9)  % 1024) / 32 * 32;
        m_by    = ((int'(userY) + 13) % 1024) / 32 * 32;
      end
      m_prev = bomb_drop;
      if (!bomb_drop) m_primed = 1;
    end
  end

  // 0 = no bomb, 1 = fuse running, 2 = blast live
  function automatic int phase();
    int j;
    if (!m_armed) return 0;
    j = m_n - m_a;
    if (j < F)     return 1;
    if (j < F + B) return 2;
    return 0;
  endfunction

  function automatic bit inside_box(int px, int py, int ox, int oy, int w, int h);
    return px >= ox && px < ox + w && py >= oy && py < oy + h;
  endfunction

  task automatic check_all();
    int ph, bx, by, hs, he, hsz, vs, ve, vsz;
    int e_hx, e_hy, e_hxs, e_hys, e_vx, e_vy, e_vxs, e_vys;
    bit e_bon, e_blon;
    ph = phase();
    bx = (ph != 0) ? m_bx : 0;
    by = (ph != 0) ? m_by : 0;
    hs = m_bx - 32; if (hs < 32) hs = 32;
    he = m_bx + 64; if (he > 576) he = 576;
    hsz = (he > hs) ? he - hs : 0;
    vs = m_by - 32; if (vs < 32) vs = 32;
    ve = m_by + 64; if (ve > 448) ve = 448;
    vsz = (ve > vs) ? ve - vs : 0;
    if (ph == 2) begin
      e_hx = hs; e_hy = m_by; e_hxs = hsz; e_hys = 32;
      e_vx = m_bx; e_vy = vs; e_vxs = 32; e_vys = vsz;
    end else begin
      e_hx = 0; e_hy = 0; e_hxs = 0; e_hys = 0;
      e_vx = 0; e_vy = 0; e_vxs = 0; e_vys = 0;
    end
    e_bon  = (ph == 1) && inside_box(int'(DrawX), int'(DrawY), m_bx, m_by, 32, 32);
    e_blon = (ph == 2) && (inside_box(int'(DrawX), int'(DrawY), e_hx, e_hy, e_hxs, e_hys) ||
                           inside_box(int'(DrawX), int'(DrawY), e_vx, e_vy, e_vxs, e_vys));
    chk("bomb_active", int'(bomb_active), int'(ph == 1));
    chk("blast",       int'(blast),       int'(ph == 2));
    chk("bombX",       int'(bombX),       bx);
    chk("bombY",       int'(bombY),       by);
    chk("blastHX",     int'(blastHX),     e_hx);
    chk("blastHY",     int'(blastHY),     e_hy);
    chk("blastHXS",    int'(blastHXS),    e_hxs);
    chk("blastHYS",    int'(blastHYS),    e_hys);
    chk("blastVX",     int'(blastVX),     e_vx);
    chk("blastVY",     int'(blastVY),     e_vy);
    chk("blastVXS",    int'(blastVXS),    e_vxs);
    chk("blastVYS",    int'(blastVYS),    e_vys);
    chk("bomb_on",     int'(bomb_on),     int'(e_bon));
    chk("blast_on",    int'(blast_on),    int'(e_blon));
  endtask

  bit cmp_en = 0;
  always @(negedge frame_clk) if (cmp_en && !Reset) check_all();

  task automatic step(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_active"}, int'(bomb_active), 0);
    chk({tag, "_blast"},  int'(blast),       0);
    chk({tag, "_bombX"},  int'(bombX),       0);
    chk({tag, "_bombY"},  int'(bombY),       0);
    chk({tag, "_HX"},     int'(blastHX),     0);
    chk({tag, "_HXS"},    int'(blastHXS),    0);
    chk({tag, "_VY"},     int'(blastVY),     0);
    chk({tag, "_VYS"},    int'(blastVYS),    0);
    chk({tag, "_on"},     int'(bomb_on | blast_on), 0);
  endtask

  initial begin
    int arms;
    bit pa;
    int r;

    #1 Reset = 1'b1;
    #10;
    chk_all_zero("reset");
    Reset = 1'b0;
    cmp_en = 1;
    step(2);

    // Bomb at the top-left corner of the arena.
    userX = 10'd34; userY = 10'd34; bomb_drop = 1'b1;
    step(1);
    bomb_drop = 1'b0;
    chk("tl_active", int'(bomb_active), 1);
    chk("tl_bombX",  int'(bombX), 32);
    chk("tl_bombY",  int'(bombY), 32);
    DrawX = 10'd40; DrawY = 10'd40; #1;
    chk("tl_bomb_on_in",  int'(bomb_on), 1);
    DrawX = 10'd64; #1;
    chk("tl_bomb_on_out", int'(bomb_on), 0);
    step(119);
    chk("tl_fuse_end_blast", int'(blast), 0);
    step(1);
    chk("tl_blast", int'(blast), 1);
    chk("tl_HX",  int'(blastHX), 32);  chk("tl_HY",  int'(blastHY), 32);
    chk("tl_HXS", int'(blastHXS), 64); chk("tl_HYS", int'(blastHYS), 32);
    chk("tl_VX",  int'(blastVX), 32);  chk("tl_VY",  int'(blastVY), 32);
    chk("tl_VXS", int'(blastVXS), 32); chk("tl_VYS", int'(blastVYS), 64);
    step(29);
    chk("tl_blast_last", int'(blast), 1);
    step(1);
    chk_all_zero("tl_done");

    // Bottom-right corner; a second drop edge mid-fuse must be ignored.
    userX = 10'd550; userY = 10'd420; bomb_drop = 1'b1;
    step(1);
    bomb_drop = 1'b0;
    chk("br_bombX", int'(bombX), 544);
    chk("br_bombY", int'(bombY), 416);
    step(49);
    userX = 10'd100; userY = 10'd100; bomb_drop = 1'b1;
    step(1);
    bomb_drop = 1'b0;
    chk("br_redrop_bombX", int'(bombX), 544);
    chk("br_redrop_bombY", int'(bombY), 416);
    step(69);
    chk("br_fuse_end_blast", int'(blast), 0);
    step(1);
    chk("br_blast", int'(blast), 1);
    chk("br_HX",  int'(blastHX), 512); chk("br_HY",  int'(blastHY), 416);
    chk("br_HXS", int'(blastHXS), 64); chk("br_HYS", int'(blastHYS), 32);
    chk("br_VX",  int'(blastVX), 544); chk("br_VY",  int'(blastVY), 384);
    chk("br_VXS", int'(blastVXS), 32); chk("br_VYS", int'(blastVYS), 64);
    step(30);
    chk("br_done_blast", int'(blast), 0);

    // Held drop gives exactly one bomb; low-then-high re-arms.
    bomb_drop = 1'b1;
    arms = 0; pa = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (bomb_active && !pa) arms++;
      pa = bomb_active;
    end
    chk("held_arms", arms, 1);
    chk("held_idle_active", int'(bomb_active), 0);
    bomb_drop = 1'b0;
    step(1);
    bomb_drop = 1'b1;
    step(1);
    chk("rearm_active", int'(bomb_active), 1);

    // Reset during blast frame 10 with drop held through reset.
    step(130);
    chk("pre_reset_blast", int'(blast), 1);
    #2 Reset = 1'b1;
    #1;
    chk_all_zero("mid_blast_reset");
    step(2);
    Reset = 1'b0;
    step(5);
    chk("held_through_reset", int'(bomb_active), 0);
    bomb_drop = 1'b0;
    step(1);
    bomb_drop = 1'b1;
    step(1);
    chk("post_reset_rearm", int'(bomb_active), 1);
    bomb_drop = 1'b0;
    step(160);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 15) == 0) bomb_drop = ~bomb_drop;
      userX = 10'($urandom_range(0, 1023));
      userY = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 0) begin
        r = m_bx + int'($urandom_range(0, 159)) - 64;
        DrawX = 10'(r & 1023);
        r = m_by + int'($urandom_range(0, 159)) - 64;
        DrawY = 10'(r & 1023);
      end else begin
        DrawX = 10'($urandom_range(0, 1023));
        DrawY = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 999) == 0) begin
        Reset = 1'b1;
        #1;
        chk("rand_reset_active", int'(bomb_active | blast), 0);
        step(1);
        Reset = 1'b0;
      end
      step(1);
    end

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
